// File: rtl/clock_monitor_if.sv
// clock_monitor_if
//   Bundles the slow-clock observation signals of clock_monitor.
//   master : the monitor side (samples slow_in, drives the status outputs)
//   slave  : the consumer side (drives slow_in, reads the status outputs)
// Signals
//   slow_in      monitored slow clock
//   rise         one-cycle strobe per rising edge of slow_in
//   fall         one-cycle strobe per falling edge of slow_in
//   period       last measured rise-to-rise distance in clk cycles (CNT_W bits)
//   period_valid one-cycle strobe when period updates
//   lock         high while slow_in is stable and in tolerance
//   err          sticky fault flag, cleared only by reset
interface clock_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             slow_in;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             lock;
    logic             err;

    modport master (
        input  slow_in,
        output rise, fall, period, period_valid, lock, err
    );

    modport slave (
        output slow_in,
        input  rise, fall, period, period_valid, lock, err
    );
endinterface

// File: rtl/clock_monitor.sv
// clock_monitor
//   Runs on the fast board clock and watches a slow clock (divided clock or any
//   slower strobe). Recovers one-cycle rise/fall enables, measures the rise-to-rise
//   period in fast cycles, declares lock after LOCK_CNT consecutive good periods
//   and raises a sticky err on a bad period or a stall while locked.
// Ports
//   clk    in  board clock, all logic on its rising edge
//   reset  in  synchronous, active-high
//   mon    clock_monitor_if.master: slow_in in; rise, fall, period,
//          period_valid, lock, err out
// Parameters
//   CNT_W, EXP_PERIOD, TOL, LOCK_CNT, TIMEOUT (TIMEOUT > EXP_PERIOD + TOL)
// Configuration
//   CLOCK_MONITOR_SYNC_EN : when defined, slow_in passes a 2-flop synchronizer
//   ahead of the sample register (asynchronous sources). Strobes arrive 2 cycles
//   later; measured periods are unchanged.
module clock_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned EXP_PERIOD = 3,
    parameter int unsigned TOL        = 0,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic            clk,
    input  logic            reset,
    clock_monitor_if.master mon
);

    localparam int unsigned GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT);

    localparam logic [CNT_W-1:0]     CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]     CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0]    GOOD_LAST   = GOOD_W'(LOCK_CNT - 1);
    localparam logic signed [CNT_W:0] EXP_S      = (CNT_W + 1)'(EXP_PERIOD);
    localparam logic signed [CNT_W:0] TOL_S      = (CNT_W + 1)'(TOL);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCKED
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic s_src;

`ifdef CLOCK_MONITOR_SYNC_EN
    logic sync_a;
    logic sync_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= mon.slow_in;
            sync_b <= sync_a;
        end
    end

    always_comb s_src = sync_b;
`else
    always_comb s_src = mon.slow_in;
`endif

    // ------------------------------------------------------------------
    // Edge detection (all registered)
    // ------------------------------------------------------------------
    logic s_q;
    logic s_prev;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q    <= 1'b0;
            s_prev <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s_q    <= s_src;
            s_prev <= s_q;
            rise_q <= s_q & ~s_prev;
            fall_q <= ~s_q & s_prev;
        end
    end

    // ------------------------------------------------------------------
    // Period counter and measurement
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_q;
    logic             period_valid_q;
    logic             seen_rise;
    logic             meas;
    logic             timeout;
    logic             good;
    logic signed [CNT_W:0] diff;

    // cnt restarts at 1 on the rise strobe so that, at the next strobe, it holds
    // exactly the number of clk cycles between the two strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise_q) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The first rise after reset only arms the measurement; it is never timed.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_rise      <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            if (rise_q) begin
                seen_rise <= 1'b1;
                if (seen_rise) begin
                    period_q       <= cnt;
                    period_valid_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        meas    = rise_q & seen_rise;
        timeout = (cnt == CNT_TIMEOUT);
        diff    = $signed({1'b0, cnt}) - EXP_S;
        good    = (diff <= TOL_S) && (diff >= -TOL_S);
    end

    // ------------------------------------------------------------------
    // Lock FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_nxt;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_nxt;
    logic              err_q;
    logic              err_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ACQ;
            good_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            err_q    <= err_nxt;
        end
    end

    // A rise strobe always takes priority over the timeout test, so a period
    // that lands exactly on TIMEOUT is judged as a (bad) period, not a stall.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_nxt   = err_q;
        case (state)
            IDLE: begin
                if (rise_q) begin
                    state_nxt = ACQ;
                    good_nxt  = '0;
                end
            end
            ACQ: begin
                if (rise_q) begin
                    if (meas) begin
                        if (!good) begin
                            good_nxt = '0;
                        end else if (good_cnt == GOOD_LAST) begin
                            state_nxt = LOCKED;
                            good_nxt  = '0;
                        end else begin
                            good_nxt = good_cnt + 1'b1;
                        end
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                    good_nxt  = '0;
                end
            end
            LOCKED: begin
                if (rise_q) begin
                    if (meas && !good) begin
                        state_nxt = ACQ;
                        good_nxt  = '0;
                        err_nxt   = 1'b1;
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                    good_nxt  = '0;
                    err_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                good_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        mon.rise         = rise_q;
        mon.fall         = fall_q;
        mon.period       = period_q;
        mon.period_valid = period_valid_q;
        mon.lock         = (state == LOCKED);
        mon.err          = err_q;
    end

endmodule
